// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline-control bundle between the Y86-64 datapath and pipe_hazard_ctrl.
// master: datapath side (drives stage state, receives stall/bubble controls).
// slave:  hazard controller side.
interface pipe_hazard_ctrl_if;
    logic [3:0] D_icode;
    logic [3:0] d_srcA;
    logic [3:0] d_srcB;
    logic [3:0] E_icode;
    logic [3:0] E_dstM;
    logic       e_Cnd;
    logic [3:0] M_icode;
    logic [2:0] m_stat;
    logic [2:0] W_stat;

    logic       F_stall;
    logic       D_stall;
    logic       D_bubble;
    logic       E_bubble;
    logic       M_bubble;
    logic       W_stall;
    logic       halted;
    logic [2:0] halt_stat;

    modport master (
        output D_icode, d_srcA, d_srcB, E_icode, E_dstM, e_Cnd, M_icode, m_stat, W_stat,
        input  F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, halted, halt_stat
    );

    modport slave (
        input  D_icode, d_srcA, d_srcB, E_icode, E_dstM, e_Cnd, M_icode, m_stat, W_stat,
        output F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, halted, halt_stat
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/exception controller for the 5-stage Y86-64 pipeline.
// Produces stall/bubble controls for the F/D/E/M/W pipeline registers from
// current stage state (load-use, mispredicted jXX, ret drain, exception
// freeze) and keeps a sticky RUN/DRAIN/HALT state machine.
// Optional macro PIPE_PERF_CNT_EN adds cyc_cnt/stall_cnt/mp_cnt counters
// (CNT_W bits each); without it the ports, counters and CNT_W are absent.
module pipe_hazard_ctrl
`ifdef PIPE_PERF_CNT_EN
#(
    parameter int unsigned CNT_W = 32
)
`endif
(
    input  logic              clk,
    input  logic              rst,
    pipe_hazard_ctrl_if.slave hz
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]  cyc_cnt,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  mp_cnt
`endif
);

    localparam logic [3:0] IC_MRMOVQ = 4'h5;
    localparam logic [3:0] IC_JXX    = 4'h7;
    localparam logic [3:0] IC_RET    = 4'h9;
    localparam logic [3:0] IC_POPQ   = 4'hB;
    localparam logic [2:0] ST_AOK    = 3'd1;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [2:0] halt_stat_q;

    logic lu_reg_hit;
    logic lu;
    logic mp;
    logic rt;
    logic exc_m;
    logic exc_w;

    // Case equality keeps unknown inputs from ever counting as a match.
    function automatic logic is_exc(input logic [2:0] s);
        return (s === 3'd2) || (s === 3'd3) || (s === 3'd4);
    endfunction

    // Load-use register match: only known, real registers (0..14) can hit, so
    // x or 4'hF never produce a hazard.
    always_comb begin
        lu_reg_hit = 1'b0;
        for (int unsigned k = 0; k < 15; k++) begin
            if ((hz.E_dstM === 4'(k)) &&
                ((hz.d_srcA === 4'(k)) || (hz.d_srcB === 4'(k))))
                lu_reg_hit = 1'b1;
        end
    end

    // Hazard terms derived from the current stage contents.
    always_comb begin
        lu    = ((hz.E_icode === IC_MRMOVQ) || (hz.E_icode === IC_POPQ)) && lu_reg_hit;
        mp    = (hz.E_icode === IC_JXX) && (hz.e_Cnd === 1'b0);
        rt    = (hz.D_icode === IC_RET) || (hz.E_icode === IC_RET) ||
                (hz.M_icode === IC_RET);
        exc_m = is_exc(hz.m_stat);
        exc_w = is_exc(hz.W_stat);
    end

    // Next-state and pipeline-register controls; reset flush overrides all.
    always_comb begin
        state_nxt   = state;
        hz.F_stall  = 1'b0;
        hz.D_stall  = 1'b0;
        hz.D_bubble = 1'b0;
        hz.E_bubble = 1'b0;
        hz.M_bubble = 1'b0;
        hz.W_stall  = 1'b0;

        case (state)
            RUN: begin
                hz.F_stall  = lu | rt;
                hz.D_stall  = lu & ~mp;
                hz.D_bubble = mp | (rt & ~lu);
                hz.E_bubble = mp | lu;
                hz.M_bubble = exc_m | exc_w;
                hz.W_stall  = exc_w;
                if (exc_w)
                    state_nxt = HALT;
                else if (exc_m)
                    state_nxt = DRAIN;
            end
            DRAIN: begin
                hz.F_stall  = 1'b1;
                hz.D_stall  = 1'b1;
                hz.M_bubble = 1'b1;
                hz.W_stall  = exc_w;
                if (exc_w)
                    state_nxt = HALT;
            end
            HALT: begin
                hz.F_stall  = 1'b1;
                hz.D_stall  = 1'b1;
                hz.M_bubble = 1'b1;
                hz.W_stall  = 1'b1;
            end
            default: state_nxt = RUN;
        endcase

        if (rst) begin
            state_nxt   = RUN;
            hz.F_stall  = 1'b0;
            hz.D_stall  = 1'b0;
            hz.W_stall  = 1'b0;
            hz.D_bubble = 1'b1;
            hz.E_bubble = 1'b1;
            hz.M_bubble = 1'b1;
        end
    end

    // State register; halt_stat captures W_stat only on the edge into HALT.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RUN;
            halt_stat_q <= ST_AOK;
        end else begin
            state <= state_nxt;
            if ((state != HALT) && (state_nxt == HALT))
                halt_stat_q <= hz.W_stat;
        end
    end

    assign hz.halted    = (state == HALT);
    assign hz.halt_stat = halt_stat_q;

`ifdef PIPE_PERF_CNT_EN
    // Performance counters: advance while not halted, wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_cnt   <= '0;
            stall_cnt <= '0;
            mp_cnt    <= '0;
        end else if (state != HALT) begin
            cyc_cnt <= cyc_cnt + CNT_W'(1);
            if (lu | rt)
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (mp)
                mp_cnt <= mp_cnt + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios followed by
// randomized stage contents, all compared against a behavioural model.
module tb_pipe_hazard_ctrl;

    logic clk = 1'b0;
    logic rst;

    pipe_hazard_ctrl_if bus ();

`ifdef PIPE_PERF_CNT_EN
    logic [31:0] cyc_cnt;
    logic [31:0] stall_cnt;
    logic [31:0] mp_cnt;

    pipe_hazard_ctrl #(.CNT_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .hz        (bus),
        .cyc_cnt   (cyc_cnt),
        .stall_cnt (stall_cnt),
        .mp_cnt    (mp_cnt)
    );
`else
    pipe_hazard_ctrl dut (
        .clk (clk),
        .rst (rst),
        .hz  (bus)
    );
`endif

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    bit          m_stopped;
    bit          m_draining;
    logic [2:0]  m_hstat;
    logic [31:0] m_cyc;
    logic [31:0] m_stall;
    logic [31:0] m_mp;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit exc(input logic [2:0] s);
        return s inside {3'd2, 3'd3, 3'd4};
    endfunction

    function automatic bit lu_now();
        return (bus.E_icode inside {4'h5, 4'hB}) && (bus.E_dstM != 4'hF) &&
               ((bus.E_dstM == bus.d_srcA) || (bus.E_dstM == bus.d_srcB));
    endfunction

    function automatic bit mp_now();
        return (bus.E_icode == 4'h7) && !bus.e_Cnd;
    endfunction

    function automatic bit rt_now();
        return (bus.D_icode == 4'h9) || (bus.E_icode == 4'h9) || (bus.M_icode == 4'h9);
    endfunction

    // {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall}
    function automatic logic [5:0] exp_ctrl();
        bit lu, mp, rt;
        lu = lu_now();
        mp = mp_now();
        rt = rt_now();
        if (rst)        return 6'b001110;
        if (m_stopped)  return 6'b110011;
        if (m_draining) return {5'b11001, exc(bus.W_stat)};
        return {lu | rt, lu & !mp, mp | (rt & !lu), mp | lu,
                exc(bus.m_stat) | exc(bus.W_stat), exc(bus.W_stat)};
    endfunction

    function automatic logic [5:0] dut_ctrl();
        return {bus.F_stall, bus.D_stall, bus.D_bubble, bus.E_bubble, bus.M_bubble, bus.W_stall};
    endfunction

    task automatic idle();
        bus.D_icode = 4'h0;
        bus.d_srcA  = 4'hF;
        bus.d_srcB  = 4'hF;
        bus.E_icode = 4'h0;
        bus.E_dstM  = 4'hF;
        bus.e_Cnd   = 1'b1;
        bus.M_icode = 4'h0;
        bus.m_stat  = 3'd1;
        bus.W_stat  = 3'd1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".ctrl"}, 32'(dut_ctrl()), 32'(exp_ctrl()));
        chk({tag, ".halted"}, 32'(bus.halted), 32'(m_stopped));
        chk({tag, ".halt_stat"}, 32'(bus.halt_stat), 32'(m_hstat));
`ifdef PIPE_PERF_CNT_EN
        chk({tag, ".cyc_cnt"}, cyc_cnt, m_cyc);
        chk({tag, ".stall_cnt"}, stall_cnt, m_stall);
        chk({tag, ".mp_cnt"}, mp_cnt, m_mp);
`endif
    endtask

    // Advance one clock and apply the architectural rules to the model.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            m_stopped  = 1'b0;
            m_draining = 1'b0;
            m_hstat    = 3'd1;
            m_cyc      = '0;
            m_stall    = '0;
            m_mp       = '0;
        end else if (!m_stopped) begin
            m_cyc = m_cyc + 1;
            if (lu_now() || rt_now()) m_stall = m_stall + 1;
            if (mp_now())             m_mp    = m_mp + 1;
            if (exc(bus.W_stat)) begin
                m_stopped  = 1'b1;
                m_draining = 1'b0;
                m_hstat    = bus.W_stat;
            end else if (exc(bus.m_stat)) begin
                m_draining = 1'b1;
            end
        end
        @(negedge clk);
    endtask

    function automatic logic [3:0] rand_icode();
        case ($urandom_range(0, 5))
            0: return 4'h5;
            1: return 4'h7;
            2: return 4'h9;
            3: return 4'hB;
            4: return 4'h0;
            default: return 4'($urandom_range(0, 15));
        endcase
    endfunction

    function automatic logic [3:0] rand_reg();
        int unsigned v;
        v = $urandom_range(0, 4);
        return (v == 4) ? 4'hF : 4'(v);
    endfunction

    function automatic logic [2:0] rand_stat();
        return ($urandom_range(0, 29) == 0) ? 3'($urandom_range(0, 7)) : 3'd1;
    endfunction

    task automatic randomize_inputs();
        bus.D_icode = rand_icode();
        bus.d_srcA  = rand_reg();
        bus.d_srcB  = rand_reg();
        bus.E_icode = rand_icode();
        bus.E_dstM  = rand_reg();
        bus.e_Cnd   = 1'($urandom_range(0, 1));
        bus.M_icode = rand_icode();
        bus.m_stat  = rand_stat();
        bus.W_stat  = rand_stat();
    endtask

    initial begin
        // Reset flush, two cycles; first edge establishes known state.
        idle();
        rst = 1'b1;
        tick();
        settle();
        check_model("reset");
        chk("reset.halted0", 32'(bus.halted), 32'd0);
        chk("reset.hstat1", 32'(bus.halt_stat), 32'd1);
        chk("reset.flush", 32'(dut_ctrl()), 32'(6'b001110));
        tick();
        rst = 1'b0;

        // Load-use for exactly one cycle
        idle();
        bus.E_icode = 4'h5; bus.E_dstM = 4'h3; bus.d_srcA = 4'h3;
        settle();
        check_model("lu");
        chk("lu.bits", 32'(dut_ctrl()), 32'(6'b110100));
        tick();
        idle();
        settle();
        check_model("lu_after");
        chk("lu_after.F_stall", 32'(bus.F_stall), 32'd0);
        tick();

        // Mispredict then correct prediction
        bus.E_icode = 4'h7; bus.e_Cnd = 1'b0;
        settle();
        check_model("mp");
        chk("mp.bits", 32'(dut_ctrl()), 32'(6'b001100));
        tick();
        bus.e_Cnd = 1'b1;
        settle();
        check_model("mp_taken");
        chk("mp_taken.bits", 32'(dut_ctrl()), 32'd0);
        tick();

        // Ret walks D -> E -> M, clear on the 4th cycle
        idle();
        for (int i = 0; i < 4; i++) begin
            bus.D_icode = (i == 0) ? 4'h9 : 4'h0;
            bus.E_icode = (i == 1) ? 4'h9 : 4'h0;
            bus.M_icode = (i == 2) ? 4'h9 : 4'h0;
            settle();
            check_model("ret");
            chk("ret.F_stall", 32'(bus.F_stall), (i < 3) ? 32'd1 : 32'd0);
            chk("ret.D_bubble", 32'(bus.D_bubble), (i < 3) ? 32'd1 : 32'd0);
            tick();
        end

        // Ret in D combined with load-use
        idle();
        bus.D_icode = 4'h9; bus.E_icode = 4'h5; bus.E_dstM = 4'h3; bus.d_srcA = 4'h3;
        settle();
        check_model("ret_lu");
        chk("ret_lu.D_stall", 32'(bus.D_stall), 32'd1);
        chk("ret_lu.D_bubble", 32'(bus.D_bubble), 32'd0);
        chk("ret_lu.E_bubble", 32'(bus.E_bubble), 32'd1);
        tick();

        // Ten RUN cycles after a reset
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            settle();
            check_model("run10");
            tick();
        end
`ifdef PIPE_PERF_CNT_EN
        chk("run10.cyc_cnt", cyc_cnt, 32'd10);
`endif

        // Exception: m_stat=ADR then W_stat=ADR -> DRAIN then HALT
        bus.m_stat = 3'd3;
        settle();
        check_model("exc_m");
        chk("exc_m.M_bubble", 32'(bus.M_bubble), 32'd1);
        tick();
        bus.m_stat = 3'd1; bus.W_stat = 3'd3;
        settle();
        check_model("drain");
        chk("drain.F_D_stall", 32'({bus.F_stall, bus.D_stall}), 32'd3);
        tick();
        for (int i = 0; i < 20; i++) begin
            randomize_inputs();
            settle();
            check_model("halt");
            chk("halt.halted", 32'(bus.halted), 32'd1);
            chk("halt.halt_stat", 32'(bus.halt_stat), 32'd3);
            tick();
        end
        rst = 1'b1;
        settle();
        check_model("halt_rst");
        tick();
        rst = 1'b0;
        idle();
        settle();
        check_model("after_halt_rst");
        chk("after_halt_rst.halted", 32'(bus.halted), 32'd0);
        chk("after_halt_rst.hstat", 32'(bus.halt_stat), 32'd1);
        tick();

        // Randomized stage contents with occasional resets
        for (int i = 0; i < 500; i++) begin
            randomize_inputs();
            rst = ($urandom_range(0, 39) == 0);
            settle();
            check_model("rand");
            tick();
        end
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
